// File: rtl/obj_pkg.sv
// obj_pkg: shared constants, state encodings and helpers for the falling-object scheduler.
// Contents: screen/object geometry, game timing constants, LFSR seed/taps,
//           top and lane state enums, LFSR step and spawn-x helpers.
package obj_pkg;

  // Screen and object geometry (pixels)
  localparam int unsigned SCR_W    = 640;
  localparam int unsigned SCR_H    = 480;
  localparam int unsigned OBJ_SIZE = 40;
  localparam int unsigned PLAYER_W = 40;
  localparam int unsigned PLAYER_H = 40;

  // Game timing (frames) and scoring
  localparam int unsigned FALL_STEP = 2;
  localparam int unsigned RESPAWN1  = 30;
  localparam int unsigned RESPAWN2  = 45;
  localparam int unsigned HIT_MAX   = 9;

  // Datapath widths
  localparam int unsigned COORD_W = 12;
  localparam int unsigned EXT_W   = 13;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned HIT_W   = 4;

  // Spawn position source
  localparam int unsigned       LFSR_W      = 10;
  localparam logic [LFSR_W-1:0] LFSR_SEED   = 10'h2A5;
  localparam int unsigned       LFSR_TAP_HI = 9;
  localparam int unsigned       LFSR_TAP_LO = 6;
  localparam int unsigned       SPAWN_OFS   = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } top_state_t;

  typedef enum logic {
    LN_WAIT = 1'b0,
    LN_FALL = 1'b1
  } lane_state_t;

  // Fibonacci step for x^10 + x^7 + 1
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

  // 9 random bits offset into the playfield; clamp keeps the box on screen
  function automatic logic [COORD_W-1:0] spawn_pos(input logic [8:0] r);
    logic [COORD_W-1:0] x;
    x = COORD_W'(r) + COORD_W'(SPAWN_OFS);
    if (x > COORD_W'(SCR_W - OBJ_SIZE)) begin
      x = COORD_W'(SCR_W - OBJ_SIZE);
    end
    return x;
  endfunction

endpackage

// File: rtl/obj_scheduler_if.sv
// obj_scheduler_if: player/display-side signals of the object scheduler.
// master drives: y_valid (vsync), start (pulse), player_x/player_y (player box).
// slave drives : obj1/obj2 x/y begin, end_show1/2, hit_count, game_over.
interface obj_scheduler_if;
  import obj_pkg::*;

  logic               y_valid;
  logic               start;
  logic [COORD_W-1:0] player_x;
  logic [COORD_W-1:0] player_y;
  logic [COORD_W-1:0] obj1_x_begin;
  logic [COORD_W-1:0] obj1_y_begin;
  logic [COORD_W-1:0] obj2_x_begin;
  logic [COORD_W-1:0] obj2_y_begin;
  logic               end_show1;
  logic               end_show2;
  logic [HIT_W-1:0]   hit_count;
  logic               game_over;

  modport master (
    output y_valid, start, player_x, player_y,
    input  obj1_x_begin, obj1_y_begin, obj2_x_begin, obj2_y_begin,
    input  end_show1, end_show2, hit_count, game_over
  );

  modport slave (
    input  y_valid, start, player_x, player_y,
    output obj1_x_begin, obj1_y_begin, obj2_x_begin, obj2_y_begin,
    output end_show1, end_show2, hit_count, game_over
  );

endinterface

// File: rtl/obj_lane.sv
// obj_lane: one falling object. WAIT counts frames until respawn, FALL moves the
// object down and tests it against the player box each frame.
// Inputs : clk_vga, rst, tick (frame strobe), run (game active), init (restart),
//          init_count (WAIT counter start), spawn_x, player_x, player_y.
// Outputs: x, y (registered), end_show (registered, 1 = hidden),
//          hit (combinational, high on the frame strobe that collides).
module obj_lane
  import obj_pkg::*;
#(
  parameter int unsigned RESPAWN = 30
) (
  input  logic               clk_vga,
  input  logic               rst,
  input  logic               tick,
  input  logic               run,
  input  logic               init,
  input  logic [CNT_W-1:0]   init_count,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               end_show,
  output logic               hit
);

  lane_state_t        state;
  logic [CNT_W-1:0]   count;
  logic [EXT_W-1:0]   ox;
  logic [EXT_W-1:0]   px;
  logic [EXT_W-1:0]   py;
  logic [EXT_W-1:0]   y_next;
  logic               overlap;
  logic               step;

  // Overlap of the object box at its next position with the player box
  always_comb begin
    ox      = EXT_W'(x);
    px      = EXT_W'(player_x);
    py      = EXT_W'(player_y);
    y_next  = EXT_W'(y) + EXT_W'(FALL_STEP);
    overlap = (ox < px + EXT_W'(PLAYER_W)) &&
              (px < ox + EXT_W'(OBJ_SIZE)) &&
              (y_next < py + EXT_W'(PLAYER_H)) &&
              (py < y_next + EXT_W'(OBJ_SIZE));
    // A restart on the same cycle swallows the frame strobe
    step    = tick && run && !init;
    hit     = step && (state == LN_FALL) && overlap;
  end

  // Lane FSM, respawn counter and position registers
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state    <= LN_WAIT;
      count    <= '0;
      x        <= '0;
      y        <= '0;
      end_show <= 1'b1;
    end else if (init) begin
      state    <= LN_WAIT;
      count    <= init_count;
      end_show <= 1'b1;
    end else if (step) begin
      unique case (state)
        LN_WAIT: begin
          end_show <= 1'b1;
          if (count == CNT_W'(RESPAWN - 1)) begin
            state    <= LN_FALL;
            count    <= '0;
            x        <= spawn_x;
            y        <= '0;
            end_show <= 1'b0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        LN_FALL: begin
          // Hit is checked first so a collision at the floor still scores
          if (overlap) begin
            state    <= LN_WAIT;
            count    <= '0;
            y        <= y_next[COORD_W-1:0];
            end_show <= 1'b1;
          end else if (y_next >= EXT_W'(SCR_H - OBJ_SIZE)) begin
            state    <= LN_WAIT;
            count    <= '0;
            y        <= COORD_W'(SCR_H - OBJ_SIZE);
            end_show <= 1'b1;
          end else begin
            y <= y_next[COORD_W-1:0];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/obj_scheduler.sv
// obj_scheduler: per-frame game controller for two falling objects.
// Ports: clk_vga, rst (sync, active-high), bus (obj_scheduler_if.slave):
//   in : y_valid (vsync, rising edge = frame tick), start, player_x, player_y
//   out: obj1/obj2 x/y begin, end_show1/2, hit_count, game_over
module obj_scheduler
  import obj_pkg::*;
(
  input  logic           clk_vga,
  input  logic           rst,
  obj_scheduler_if.slave bus
);

  localparam int unsigned SUM_W = HIT_W + 1;

  logic               y_valid_q;
  logic               tick;
  logic [LFSR_W-1:0]  lfsr;
  top_state_t         state;
  logic [HIT_W-1:0]   hit_count;
  logic [HIT_W-1:0]   hc_next;
  logic [SUM_W-1:0]   hit_sum;
  logic               game_over;
  logic               run;
  logic               hit1;
  logic               hit2;
  logic               es1;
  logic               es2;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic [COORD_W-1:0] x2;
  logic [COORD_W-1:0] y2;
  logic [COORD_W-1:0] spawn1;
  logic [COORD_W-1:0] spawn2;

  assign tick   = bus.y_valid & ~y_valid_q;
  assign run    = (state == ST_RUN);
  // Lane 2 uses a rotated view of the LFSR so the two spawns decorrelate
  assign spawn1 = spawn_pos(lfsr[8:0]);
  assign spawn2 = spawn_pos({lfsr[0], lfsr[9:2]});

  // Vsync edge register and free-running spawn LFSR
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      y_valid_q <= 1'b1;
      lfsr      <= LFSR_SEED;
    end else begin
      y_valid_q <= bus.y_valid;
      lfsr      <= lfsr_next(lfsr);
    end
  end

  // Saturating add of this frame's hits
  always_comb begin
    hit_sum = SUM_W'(hit_count) + SUM_W'(hit1) + SUM_W'(hit2);
    if (hit_sum >= SUM_W'(HIT_MAX)) begin
      hc_next = HIT_W'(HIT_MAX);
    end else begin
      hc_next = hit_sum[HIT_W-1:0];
    end
  end

  // Game FSM and score; start has priority over everything but reset
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state     <= ST_IDLE;
      hit_count <= '0;
      game_over <= 1'b0;
    end else if (bus.start) begin
      state     <= ST_RUN;
      hit_count <= '0;
      game_over <= 1'b0;
    end else if (tick && run) begin
      hit_count <= hc_next;
      if (hc_next == HIT_W'(HIT_MAX)) begin
        state     <= ST_OVER;
        game_over <= 1'b1;
      end
    end
  end

  obj_lane #(
    .RESPAWN (RESPAWN1)
  ) u_lane1 (
    .clk_vga    (clk_vga),
    .rst        (rst),
    .tick       (tick),
    .run        (run),
    .init       (bus.start),
    .init_count (CNT_W'(0)),
    .spawn_x    (spawn1),
    .player_x   (bus.player_x),
    .player_y   (bus.player_y),
    .x          (x1),
    .y          (y1),
    .end_show   (es1),
    .hit        (hit1)
  );

  obj_lane #(
    .RESPAWN (RESPAWN2)
  ) u_lane2 (
    .clk_vga    (clk_vga),
    .rst        (rst),
    .tick       (tick),
    .run        (run),
    .init       (bus.start),
    .init_count (CNT_W'(RESPAWN2 / 2)),
    .spawn_x    (spawn2),
    .player_x   (bus.player_x),
    .player_y   (bus.player_y),
    .x          (x2),
    .y          (y2),
    .end_show   (es2),
    .hit        (hit2)
  );

  assign bus.obj1_x_begin = x1;
  assign bus.obj1_y_begin = y1;
  assign bus.obj2_x_begin = x2;
  assign bus.obj2_y_begin = y2;
  // Game over hides both objects even if a lane was mid-fall
  assign bus.end_show1    = es1 | game_over;
  assign bus.end_show2    = es2 | game_over;
  assign bus.hit_count    = hit_count;
  assign bus.game_over    = game_over;

endmodule

// File: tb/tb_obj_scheduler.sv
// tb_obj_scheduler: directed, table-driven checks of obj_scheduler plus
// hand-written sequences for hits, saturation, start-on-tick and mid-game reset.
module tb_obj_scheduler;

  logic clk_vga = 1'b0;
  logic rst;

  obj_scheduler_if bus ();

  obj_scheduler dut (
    .clk_vga (clk_vga),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_vga = ~clk_vga;

  int nchecks = 0;
  int nerrors = 0;

  typedef struct {
    int ticks;
    int do_start;
    int mx1;   // 0 none, 1 expect 0, 2 expect spawn range
    int mx2;
    int es1;
    int es2;
    int y1;
    int y2;
    int hc;
    int go;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act);
    nchecks++;
    if (act < 48 || act > 559) begin
      nerrors++;
      $display("FAIL %s: got %0d expected 48..559", name, act);
    end
  endtask

  task automatic check_all(input string tag, input int es1, input int es2,
                           input int y1, input int y2, input int hc, input int go);
    chk({tag, " end_show1"}, int'(bus.end_show1), es1);
    chk({tag, " end_show2"}, int'(bus.end_show2), es2);
    chk({tag, " obj1_y"},    int'(bus.obj1_y_begin), y1);
    chk({tag, " obj2_y"},    int'(bus.obj2_y_begin), y2);
    chk({tag, " hit_count"}, int'(bus.hit_count), hc);
    chk({tag, " game_over"}, int'(bus.game_over), go);
  endtask

  // One frame: vsync high for one cycle, then low for one; ends on a negedge
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.y_valid = 1'b1;
      @(negedge clk_vga);
      bus.y_valid = 1'b0;
      @(negedge clk_vga);
    end
  endtask

  task automatic start_pulse(input bit with_tick);
    bus.start   = 1'b1;
    bus.y_valid = with_tick;
    @(negedge clk_vga);
    bus.start   = 1'b0;
    bus.y_valid = 1'b0;
    @(negedge clk_vga);
  endtask

  task automatic place(input int px, input int py);
    bus.player_x = 12'(px);
    bus.player_y = 12'(py);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    string tag;
    int    exp_hc;

    //              ticks st mx1 mx2 es1 es2  y1   y2  hc go
    vecs[0]  = '{   0,  0,  1,  1,  1,  1,   0,   0, 0, 0};
    vecs[1]  = '{   5,  0,  1,  1,  1,  1,   0,   0, 0, 0};
    vecs[2]  = '{  22,  1,  1,  1,  1,  1,   0,   0, 0, 0};
    vecs[3]  = '{   1,  0,  0,  2,  1,  0,   0,   0, 0, 0};
    vecs[4]  = '{   6,  0,  0,  0,  1,  0,   0,  12, 0, 0};
    vecs[5]  = '{   1,  0,  2,  0,  0,  0,   0,  14, 0, 0};
    vecs[6]  = '{  10,  0,  0,  0,  0,  0,  20,  34, 0, 0};
    vecs[7]  = '{ 202,  0,  0,  0,  0,  0, 424, 438, 0, 0};
    vecs[8]  = '{   1,  0,  0,  0,  0,  1, 426, 440, 0, 0};
    vecs[9]  = '{   6,  0,  0,  0,  0,  1, 438, 440, 0, 0};
    vecs[10] = '{   1,  0,  0,  0,  1,  1, 440, 440, 0, 0};
    vecs[11] = '{  29,  0,  0,  0,  1,  1, 440, 440, 0, 0};
    vecs[12] = '{   1,  0,  0,  0,  0,  1,   0, 440, 0, 0};
    vecs[13] = '{   8,  0,  0,  0,  0,  0,  16,   0, 0, 0};

    rst         = 1'b1;
    bus.y_valid = 1'b0;
    bus.start   = 1'b0;
    place(600, 440);
    repeat (2) @(negedge clk_vga);
    rst = 1'b0;

    // Reset, idle, spawn timing and misses with the player out of reach
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_start != 0) start_pulse(1'b0);
      frames(vecs[i].ticks);
      tag = $sformatf("vec%0d", i);
      check_all(tag, vecs[i].es1, vecs[i].es2, vecs[i].y1, vecs[i].y2,
                vecs[i].hc, vecs[i].go);
      if (vecs[i].mx1 == 1) chk({tag, " obj1_x"}, int'(bus.obj1_x_begin), 0);
      if (vecs[i].mx1 == 2) chk_range({tag, " obj1_x"}, int'(bus.obj1_x_begin));
      if (vecs[i].mx2 == 1) chk({tag, " obj2_x"}, int'(bus.obj2_x_begin), 0);
      if (vecs[i].mx2 == 2) chk_range({tag, " obj2_x"}, int'(bus.obj2_x_begin));
    end

    // Single hit: obj1 spawns at x=100, obj2 at x=189 (clear of the player)
    force dut.lfsr = 10'h234;
    place(90, 200);
    start_pulse(1'b0);
    frames(30);
    chk("hit spawn obj1_x", int'(bus.obj1_x_begin), 100);
    chk("hit spawn obj2_x", int'(bus.obj2_x_begin), 189);
    check_all("hit spawn", 0, 0, 0, 14, 0, 0);
    frames(80);
    check_all("hit before", 0, 0, 160, 174, 0, 0);
    frames(1);
    check_all("hit tick", 1, 0, 162, 176, 1, 0);
    frames(29);
    check_all("hit wait", 1, 0, 162, 234, 1, 0);
    frames(1);
    check_all("hit respawn", 0, 0, 0, 236, 1, 0);

    // Restart in RUN, then double hits until saturation (both x = 48)
    force dut.lfsr = 10'h000;
    place(600, 440);
    start_pulse(1'b0);
    check_all("restart", 1, 1, 0, 236, 0, 0);
    for (int r = 0; r < 5; r++) begin
      frames(r == 0 ? 60 : 59);
      place(48, 40);
      frames(1);
      place(600, 440);
      exp_hc = (2 * (r + 1) > 9) ? 9 : 2 * (r + 1);
      tag = $sformatf("double%0d", r);
      if (r == 0) begin
        chk("double0 obj1_x", int'(bus.obj1_x_begin), 48);
        chk("double0 obj2_x", int'(bus.obj2_x_begin), 48);
        check_all(tag, 1, 1, 62, 76, exp_hc, 0);
      end else begin
        check_all(tag, 1, 1, 60, 30, exp_hc, (r == 4) ? 1 : 0);
      end
    end
    place(48, 40);
    frames(5);
    check_all("over frozen", 1, 1, 60, 30, 9, 1);
    place(600, 440);
    start_pulse(1'b0);
    check_all("over restart", 1, 1, 60, 30, 0, 0);
    frames(40);
    check_all("run again", 0, 0, 20, 34, 0, 0);

    // Start coincident with a tick: restart only, no movement
    start_pulse(1'b1);
    check_all("start on tick", 1, 1, 20, 34, 0, 0);
    frames(90);
    check_all("pre reset", 0, 0, 120, 134, 0, 0);

    // Reset mid-game
    rst = 1'b1;
    @(negedge clk_vga);
    rst = 1'b0;
    check_all("mid reset", 1, 1, 0, 0, 0, 0);
    chk("mid reset obj1_x", int'(bus.obj1_x_begin), 0);
    chk("mid reset obj2_x", int'(bus.obj2_x_begin), 0);
    release dut.lfsr;
    frames(3);
    check_all("post reset idle", 1, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/obj_scheduler.md
Name: obj_scheduler

Overview:
- Game-logic controller that sequences the two falling objects drawn by the VGA display block.
- Once per frame, during vertical sync, it computes obj1/obj2 positions, their end_show (hide) flags, the hit counter and game-over status.
- Sits between the keyboard/player logic and the display; all outputs feed the display's object inputs directly.

Parameters:
- SCR_W, 640, visible width in pixels
- SCR_H, 480, visible height in pixels
- OBJ_SIZE, 40, object box edge in pixels
- PLAYER_W, 40, player box width
- PLAYER_H, 40, player box height
- FALL_STEP, 2, pixels added to object y per frame
- RESPAWN1, 30, frames obj1 stays hidden before respawn
- RESPAWN2, 45, frames obj2 stays hidden before respawn
- HIT_MAX, 9, hit count that ends the game

Ports:
- clk_vga  in  1  pixel clock (25.175 MHz)
- rst  in  1  synchronous, active-high reset
- y_valid  in  1  vsync from vga_control; a frame tick is its 0->1 edge
- start  in  1  one-cycle pulse; starts or restarts a game
- player_x  in  12  player box left edge, screen coordinates
- player_y  in  12  player box top edge
- obj1_x_begin  out  12  obj1 left edge
- obj1_y_begin  out  12  obj1 top edge
- obj2_x_begin  out  12  obj2 left edge
- obj2_y_begin  out  12  obj2 top edge
- end_show1  out  1  1 = obj1 hidden
- end_show2  out  1  1 = obj2 hidden
- hit_count  out  4  collisions this game, saturates at HIT_MAX
- game_over  out  1  high while in OVER

Behaviour:
- Clock and reset: one clock, clk_vga. Reset is synchronous, active-high, on rst.
- Reset values: all object x/y = 0, end_show1/2 = 1, hit_count = 0, game_over = 0, top FSM = IDLE, LFSR = 10'h2A5, y_valid edge register = 1 (no spurious tick in the first cycle after reset).
- Frame tick: tick = y_valid & ~y_valid_q, one cycle wide. Every frame-driven register updates on the edge where tick = 1. Outputs are stable for the whole active frame.
- LFSR: 10-bit Fibonacci, x^10+x^7+1. Advances every clock when not in reset.
- Spawn x: obj1 uses lfsr[8:0] + 48; obj2 uses {lfsr[0],lfsr[9:2]} + 48. Range 48..559, so the box always fits in SCR_W.
- Top FSM:
  - IDLE: objects hidden. On start: hit_count <= 0, both lanes go to WAIT with counters 0 and RESPAWN2/2 respectively, then RUN.
  - RUN: lanes are active. If hit_count reaches HIT_MAX on a tick, go to OVER.
  - OVER: game_over = 1, both end_show = 1, lanes frozen. On start, re-initialise as from IDLE.
  - start in RUN restarts the game the same way.
  - start coincident with tick: start wins; that tick is ignored.
- Per-lane FSM (one per object), evaluated on tick in RUN only:
  - WAIT: end_show = 1, counter increments. When counter = RESPAWNn-1: load x from the LFSR, y <= 0, counter <= 0, go to FALL.
  - FALL: end_show = 0. Per tick, compute y_next = y + FALL_STEP and evaluate in this order:
    - Overlap test, 13-bit unsigned, using y_next: ox < px+PLAYER_W, px < ox+OBJ_SIZE, y_next < py+PLAYER_H, py < y_next+OBJ_SIZE. If all hold: hit, go to WAIT, hide the object, y keeps y_next.
    - Else if y_next >= SCR_H-OBJ_SIZE: miss, go to WAIT, y <= SCR_H-OBJ_SIZE.
    - Else y <= y_next.
  - A hit takes priority over a miss in the same tick.
- hit_count: increment = number of lanes hitting on this tick (0..2). Result saturates at HIT_MAX. Hits on the same tick that reaches HIT_MAX still count, up to the saturation value.
- Latency: outputs change on the clock edge where tick = 1. They are visible one cycle after the 0->1 edge of y_valid.
- rst mid-frame or mid-game: everything returns to reset values on the next edge, whatever the state.

Decomposition:
- Shared package obj_pkg holds:
  - top-state encoding (IDLE/RUN/OVER) and lane-state encoding (WAIT/FALL);
  - screen constants SCR_W, SCR_H, OBJ_SIZE;
  - LFSR seed and taps.
- One sub-module, obj_lane, instantiated twice. It holds the lane FSM, respawn counter, x/y registers and the overlap test. Ports: tick, run, init, init_count, spawn_x, player box inputs; outputs x, y, end_show, hit.
- The top module holds the edge detector, LFSR, top FSM and hit counter.

Test Plan:
- Reset then idle ticks: assert rst for 2 cycles, then 5 y_valid edges without start -> end_show1/2 = 1, hit_count = 0, game_over = 0, all positions 0.
- Spawn timing: start, player at (600,440) -> obj1 end_show1 falls on tick 30 with y = 0 and x in 48..559; obj2 appears on tick 45-22 = 23 after start; y increases by 2 on each later tick.
- Miss: player held at (600,440), clear of every spawn x -> obj1 reaches y = 440 at the tick where y_next >= 440, end_show1 = 1, hit_count stays 0.
- Hit: force lfsr so obj1 x = 100, player at (90,200) -> end_show1 = 1 on the tick where y_next first exceeds 160; hit_count = 1; respawn follows 30 ticks later.
- Double hit and saturation: hit_count preset to 8, both objects hit on the same tick -> hit_count = 9, game_over = 1 on that tick, both end_show = 1; further ticks change nothing; start -> hit_count = 0, game_over = 0.
- Start on a tick and reset mid-game: start pulsed on the same cycle as tick -> restart only, no lane movement; rst asserted while obj1 is at y = 120 -> all outputs at reset values on the next edge.
